// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: imem geometry, bubble encoding, FSM states
// and the layout of the 64-bit F/D bus so decode can slice it consistently.
package fetch_stage_pkg;

  localparam int          IMEM_AW  = 12;
  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

  // Bit offsets of the {pc_plus1, insn} F/D bus
  localparam int FD_BUS_W    = 64;
  localparam int FD_PC1_MSB  = 63;
  localparam int FD_PC1_LSB  = 32;
  localparam int FD_INSN_MSB = 31;
  localparam int FD_INSN_LSB = 0;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc_plus1;
    logic [31:0] insn;
  } fd_entry_t;

  function automatic fd_entry_t fd_bubble();
    fd_entry_t b;
    b.valid    = 1'b0;
    b.pc_plus1 = 32'd0;
    b.insn     = NOP_INSN;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage_fd_latch.sv
// F/D pipeline latch: valid + pc_plus1 + insn, with load-enable and a synchronous
// bubble-insert that overrides the load.
module fd_latch
  import fetch_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_bubble,
  input  logic [64:0] i_d,
  output logic [64:0] o_q
);

  fd_entry_t r_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q <= fd_bubble();
    end else if (i_bubble) begin
      r_q <= fd_bubble();
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, BOOT/RUN sequencing,
// F/D latch control and the free-running cycle counter.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [31:0]          redirect_pc,
  output logic [IMEM_AW-1:0]   address_imem,
  input  logic [31:0]          q_imem,
  output logic                 fd_valid,
  output logic [31:0]          fd_pc_plus1,
  output logic [31:0]          fd_insn,
  output logic [FD_BUS_W-1:0]  outputFD,
  output logic [31:0]          cycles
);

  fetch_state_e r_state;
  fetch_state_e w_next_state;
  pc_sel_e      w_pc_sel;
  logic         w_fd_load;
  logic         w_fd_bubble;

  logic [31:0]  r_pc;
  logic [31:0]  w_pc_plus1;
  logic [31:0]  r_cycles;
  fd_entry_t    w_fd_d;
  fd_entry_t    w_fd_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_BOOT;
    else        r_state <= w_next_state;
  end

  // BOOT lasts exactly one edge; RUN is terminal until reset.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_BOOT: w_next_state = ST_RUN;
      ST_RUN:  w_next_state = ST_RUN;
      default: w_next_state = ST_BOOT;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_pc_sel    = PC_HOLD;
    w_fd_load   = 1'b0;
    w_fd_bubble = 1'b0;
    case (r_state)
      ST_BOOT: w_fd_bubble = 1'b1;
      ST_RUN: begin
        if (flush) begin
          w_pc_sel    = PC_REDIRECT;
          w_fd_bubble = 1'b1;
        end else if (!stall) begin
          w_pc_sel  = PC_INC;
          w_fd_load = 1'b1;
        end
      end
      default: w_fd_bubble = 1'b1;
    endcase
  end

  assign w_pc_plus1 = r_pc + 32'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc <= 32'd0;
    end else begin
      case (w_pc_sel)
        PC_INC:      r_pc <= w_pc_plus1;
        PC_REDIRECT: r_pc <= redirect_pc;
        default:     r_pc <= r_pc;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_cycles <= 32'd0;
    else        r_cycles <= r_cycles + 32'd1;
  end

  assign w_fd_d.valid    = 1'b1;
  assign w_fd_d.pc_plus1 = w_pc_plus1;
  assign w_fd_d.insn     = q_imem;

  fd_latch u_fd_latch (
    .clock    (clock),
    .reset    (reset),
    .i_load   (w_fd_load),
    .i_bubble (w_fd_bubble),
    .i_d      (w_fd_d),
    .o_q      (w_fd_q)
  );

  // Address truncates; the full 32-bit PC is kept for pc_plus1 reporting.
  assign address_imem = r_pc[IMEM_AW-1:0];
  assign fd_valid     = w_fd_q.valid;
  assign fd_pc_plus1  = w_fd_q.pc_plus1;
  assign fd_insn      = w_fd_q.insn;
  assign outputFD     = {w_fd_q.pc_plus1, w_fd_q.insn};
  assign cycles       = r_cycles;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes hand-computed post-edge state,
// a monitor pops and compares one entry #1 after each rising edge.
module tb_fetch_stage;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [11:0] address_imem;
  logic [31:0] q_imem;
  logic        fd_valid;
  logic [31:0] fd_pc_plus1;
  logic [31:0] fd_insn;
  logic [63:0] outputFD;
  logic [31:0] cycles;

  logic [31:0] imem [0:4095];

  typedef struct {
    logic        v;
    logic [31:0] pc1;
    logic [31:0] insn;
    logic [11:0] addr;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_pushed = 0;
  int   n_popped = 0;

  fetch_stage dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .redirect_pc  (redirect_pc),
    .address_imem (address_imem),
    .q_imem       (q_imem),
    .fd_valid     (fd_valid),
    .fd_pc_plus1  (fd_pc_plus1),
    .fd_insn      (fd_insn),
    .outputFD     (outputFD),
    .cycles       (cycles)
  );

  assign q_imem = imem[address_imem];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 64'(fd_valid), 64'd0);
    check({tag, "_insn"},  64'(fd_insn), 64'h0);
    check({tag, "_pc1"},   64'(fd_pc_plus1), 64'd0);
    check({tag, "_fdbus"}, outputFD, 64'd0);
    check({tag, "_addr"},  64'(address_imem), 64'd0);
    check({tag, "_cyc"},   64'(cycles), 64'd0);
  endtask

  // Drive one cycle of inputs, queue the state expected after the coming edge.
  task automatic step(input logic st, input logic fl, input logic [31:0] rpc,
                      input logic v, input logic [31:0] pc1, input logic [31:0] insn,
                      input logic [11:0] addr, input logic [31:0] cyc);
    exp_t e;
    stall       = st;
    flush       = fl;
    redirect_pc = rpc;
    e.v = v; e.pc1 = pc1; e.insn = insn; e.addr = addr; e.cyc = cyc;
    sb.push_back(e);
    n_pushed++;
    @(posedge clock);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("e%0d_valid", n_popped), 64'(fd_valid), 64'(e.v));
        check($sformatf("e%0d_insn", n_popped), 64'(fd_insn), 64'(e.insn));
        check($sformatf("e%0d_pc1", n_popped), 64'(fd_pc_plus1), 64'(e.pc1));
        check($sformatf("e%0d_fdbus", n_popped), outputFD, {e.pc1, e.insn});
        check($sformatf("e%0d_addr", n_popped), 64'(address_imem), 64'(e.addr));
        check($sformatf("e%0d_cyc", n_popped), 64'(cycles), 64'(e.cyc));
        n_popped++;
      end
    end
  end

  initial begin : stimulus
    for (int i = 0; i < 4096; i++) imem[i] = 32'hE000_0000 | 32'(i);
    imem[0] = 32'hA; imem[1] = 32'hB; imem[2] = 32'hC; imem[3] = 32'hD;

    reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = 32'd0;
    #3;
    check_reset_state("por");
    reset = 1'b1;

    // Test 1: boot bubble then A..D
    step(0, 0, 0, 0, 32'd0, 32'h0, 12'd0, 32'd1);
    step(0, 0, 0, 1, 32'd1, 32'hA, 12'd1, 32'd2);
    step(0, 0, 0, 1, 32'd2, 32'hB, 12'd2, 32'd3);
    step(0, 0, 0, 1, 32'd3, 32'hC, 12'd3, 32'd4);
    step(0, 0, 0, 1, 32'd4, 32'hD, 12'd4, 32'd5);

    // Test 2: return to pc=1, latch B, stall 3 cycles, resume
    step(0, 1, 32'd1, 0, 32'd0, 32'h0, 12'd1, 32'd6);
    step(0, 0, 0, 1, 32'd2, 32'hB, 12'd2, 32'd7);
    step(1, 0, 0, 1, 32'd2, 32'hB, 12'd2, 32'd8);
    step(1, 0, 0, 1, 32'd2, 32'hB, 12'd2, 32'd9);
    step(1, 0, 0, 1, 32'd2, 32'hB, 12'd2, 32'd10);
    step(0, 0, 0, 1, 32'd3, 32'hC, 12'd3, 32'd11);

    // Test 3: flush to 0x40
    step(0, 1, 32'h40, 0, 32'd0, 32'h0, 12'h040, 32'd12);
    step(0, 0, 0, 1, 32'h41, 32'hE000_0040, 12'h041, 32'd13);

    // Test 4: flush wins over stall
    step(1, 1, 32'h10, 0, 32'd0, 32'h0, 12'h010, 32'd14);
    step(0, 0, 0, 1, 32'h11, 32'hE000_0010, 12'h011, 32'd15);

    // Test 5: address wrap at 0xFFF while pc_plus1 keeps counting
    step(0, 1, 32'hFFF, 0, 32'd0, 32'h0, 12'hFFF, 32'd16);
    step(0, 0, 0, 1, 32'h1000, 32'hE000_0FFF, 12'h000, 32'd17);
    step(0, 0, 0, 1, 32'h1001, 32'hA, 12'h001, 32'd18);

    // Test 6: async reset between edges, then BOOT ignores flush
    reset = 1'b0;
    #1;
    check_reset_state("mid");
    #1;
    reset = 1'b1;
    step(0, 1, 32'h40, 0, 32'd0, 32'h0, 12'd0, 32'd1);
    step(0, 0, 0, 1, 32'd1, 32'hA, 12'd1, 32'd2);

    #10;
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("sb_popped", 64'(n_popped), 64'(n_pushed));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
